// File: rtl/bsg_link_ddr_upstream_ch_tx_if.sv
// Link bundle for the upstream channel transmitter: core-side word handshake,
// io-side beat bus, credit token return and credit status.
interface bsg_link_ddr_upstream_ch_tx_if #(
  parameter int CORE_W  = 16,
  parameter int IO_W    = 8,
  parameter int CREDITS = 16
);
  localparam int CRED_W = $clog2(CREDITS + 1);

  logic [CORE_W-1:0] core_data_i;
  logic              core_valid_i;
  logic              core_ready_o;
  logic [IO_W-1:0]   io_data_o;
  logic              io_valid_o;
  logic              io_token_i;
  logic [CRED_W-1:0] credits_o;
  logic              credit_err_o;

  // Producer view: supplies core words and the returning token, observes the bus.
  modport master (
    output core_data_i, core_valid_i, io_token_i,
    input  core_ready_o, io_data_o, io_valid_o, credits_o, credit_err_o
  );

  // Transmitter view.
  modport slave (
    input  core_data_i, core_valid_i, io_token_i,
    output core_ready_o, io_data_o, io_valid_o, credits_o, credit_err_o
  );
endinterface

// File: rtl/bsg_link_ddr_upstream_ch_tx.sv
// Upstream channel transmitter: serializes wide core words LSB beat first onto
// the io bus, back-to-back without gaps, gated by a credit counter that is
// replenished by toggles on the asynchronous io_token_i line.
module bsg_link_ddr_upstream_ch_tx #(
  parameter int CORE_W      = 16,
  parameter int IO_W        = 8,
  parameter int CREDITS     = 16,
  parameter int TOKEN_BATCH = 4
) (
  input logic clk,
  input logic rst,
  bsg_link_ddr_upstream_ch_tx_if.slave link
);

  localparam int NUM_BEATS = CORE_W / IO_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int CRED_W    = $clog2(CREDITS + 1);
  // Wide enough to hold credits + TOKEN_BATCH before clamping.
  localparam int SUM_W     = $clog2(CREDITS + TOKEN_BATCH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [CORE_W-1:0] shift_r;
  logic [IO_W-1:0]   io_data_r;
  logic              io_valid_r;
  logic [CRED_W-1:0] credits_r;
  logic              credit_err_r;
  logic              sync1_r;
  logic              sync2_r;
  logic              prev_r;

  logic              last_beat_s;
  logic              ready_s;
  logic              accept_s;
  logic              token_edge_s;
  logic [SUM_W-1:0]  credits_sum_s;
  logic              overflow_s;
  logic [CRED_W-1:0] credits_next_s;

  assign last_beat_s  = (beat_cnt_r == LAST_BEAT);
  assign accept_s     = link.core_valid_i & ready_s;
  // Either polarity of the synchronized token line returns a batch of credits.
  assign token_edge_s = sync2_r ^ prev_r;

  // Ready depends only on registered state (and rst), never on core_valid_i.
  always_comb begin
    ready_s = 1'b0;
    if (!rst && (credits_r != {CRED_W{1'b0}}) &&
        ((state_r == ST_IDLE) || last_beat_s)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Next credit value: add a returned batch first so the decrement never underflows, then clamp.
  always_comb begin
    credits_sum_s  = SUM_W'(credits_r);
    overflow_s     = 1'b0;
    credits_next_s = credits_r;
    if (token_edge_s) begin
      credits_sum_s = credits_sum_s + SUM_W'(TOKEN_BATCH);
    end else begin
      credits_sum_s = credits_sum_s;
    end
    if (accept_s) begin
      credits_sum_s = credits_sum_s - SUM_W'(1);
    end else begin
      credits_sum_s = credits_sum_s;
    end
    if (credits_sum_s > SUM_W'(CREDITS)) begin
      overflow_s     = 1'b1;
      credits_next_s = CRED_W'(CREDITS);
    end else begin
      overflow_s     = 1'b0;
      credits_next_s = CRED_W'(credits_sum_s);
    end
  end

  // Serializer FSM: presents one beat per cycle, reloading on the last beat for gapless streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= {CNT_W{1'b0}};
      shift_r    <= {CORE_W{1'b0}};
      io_data_r  <= {IO_W{1'b0}};
      io_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            io_data_r  <= link.core_data_i[IO_W-1:0];
            shift_r    <= link.core_data_i >> IO_W;
            io_valid_r <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
            state_r    <= ST_SEND;
          end else begin
            io_valid_r <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!last_beat_s) begin
            io_data_r  <= shift_r[IO_W-1:0];
            shift_r    <= shift_r >> IO_W;
            io_valid_r <= 1'b1;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end else if (accept_s) begin
            io_data_r  <= link.core_data_i[IO_W-1:0];
            shift_r    <= link.core_data_i >> IO_W;
            io_valid_r <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
          end else begin
            io_valid_r <= 1'b0;
            beat_cnt_r <= {CNT_W{1'b0}};
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          io_valid_r <= 1'b0;
          beat_cnt_r <= {CNT_W{1'b0}};
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r    <= CRED_W'(CREDITS);
      credit_err_r <= 1'b0;
    end else begin
      credits_r <= credits_next_s;
      if (overflow_s) begin
        credit_err_r <= 1'b1;
      end else begin
        credit_err_r <= credit_err_r;
      end
    end
  end

  // Two-flop synchronizer for the async token line plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= link.io_token_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign link.core_ready_o = ready_s;
  assign link.io_data_o    = io_data_r;
  assign link.io_valid_o   = io_valid_r;
  assign link.credits_o    = credits_r;
  assign link.credit_err_o = credit_err_r;

endmodule
